// File: rtl/wb_arbiter_pkg.sv
// Shared widths, writeback mux select codes and the round-robin step helper.
// Select codes match what the 3:1 bus-to-regfile data mux decodes.
package wb_arbiter_pkg;

    localparam int DEF_DATAWIDTH    = 16;
    localparam int DEF_REGADDRWIDTH = 4;

    typedef enum logic [1:0] {
        WB_SEL_ALU = 2'b00,
        WB_SEL_MEM = 2'b01,
        WB_SEL_IO  = 2'b10
    } wb_sel_e;

    // Next index in the 0 -> 1 -> 2 -> 0 rotation; never produces 2'b11.
    function automatic logic [1:0] rr_next(input logic [1:0] idx);
        return (idx >= 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Writeback bus: three request sources on one side, the regfile write port on the other.
// master = the arbiter driving the regfile port; slave = the sources and regfile around it.
interface wb_arbiter_if #(
    parameter int DATAWIDTH = 16,
    parameter int ADDRWIDTH = 4
);
    logic [2:0]           req;
    logic [ADDRWIDTH-1:0] addr0;
    logic [ADDRWIDTH-1:0] addr1;
    logic [ADDRWIDTH-1:0] addr2;
    logic [DATAWIDTH-1:0] data0;
    logic [DATAWIDTH-1:0] data1;
    logic [DATAWIDTH-1:0] data2;
    logic [2:0]           grant;
    logic                 wb_rdy;
    logic                 wb_we;
    logic [1:0]           wb_sel;
    logic [ADDRWIDTH-1:0] wb_addr;
    logic [DATAWIDTH-1:0] wb_data;

    modport master (
        input  req, addr0, addr1, addr2, data0, data1, data2, wb_rdy,
        output grant, wb_we, wb_sel, wb_addr, wb_data
    );

    modport slave (
        output req, addr0, addr1, addr2, data0, data1, data2, wb_rdy,
        input  grant, wb_we, wb_sel, wb_addr, wb_data
    );

endinterface

// File: rtl/wb_arbiter_rr_arb3.sv
// Combinational 3-way round-robin: first requester after last wins, one-hot grant plus index.
// Zero latency; en low (stage busy or reset) suppresses every grant.
module rr_arb3
    import wb_arbiter_pkg::*;
(
    input  logic       en,
    input  logic [1:0] last,
    input  logic [2:0] req,
    output logic [2:0] grant,
    output logic [1:0] idx
);

    always_comb begin
        logic [1:0] cand;
        grant = 3'b000;
        idx   = last;
        cand  = last;
        for (int k = 0; k < 3; k++) begin
            cand = rr_next(cand);
            if (en && (grant == 3'b000) && req[cand]) begin
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin writeback arbiter: three sources onto one registered regfile write port.
// Grant to wb_we is 1 cycle; wb_rdy low with wb_we high holds the stage and blocks all grants.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int DATAWIDTH = DEF_DATAWIDTH,
    parameter int ADDRWIDTH = DEF_REGADDRWIDTH
) (
    input logic          clk,
    input logic          rst_n,
    wb_arbiter_if.master bus
);

    logic [1:0]           last;
    logic                 wb_we_q;
    logic [1:0]           wb_sel_q;
    logic [ADDRWIDTH-1:0] wb_addr_q;
    logic [DATAWIDTH-1:0] wb_data_q;

    logic                 stage_free;
    logic                 arb_en;
    logic [2:0]           grant;
    logic [1:0]           idx;
    logic [ADDRWIDTH-1:0] mux_addr;
    logic [DATAWIDTH-1:0] mux_data;

    assign stage_free = !wb_we_q || bus.wb_rdy;
    // Grants are gated by rst_n so no source is released while the stage is held in reset.
    assign arb_en     = stage_free && rst_n;

    rr_arb3 u_rr_arb3 (
        .en    (arb_en),
        .last  (last),
        .req   (bus.req),
        .grant (grant),
        .idx   (idx)
    );

    always_comb begin
        mux_addr = bus.addr0;
        mux_data = bus.data0;
        case (idx)
            WB_SEL_MEM: begin
                mux_addr = bus.addr1;
                mux_data = bus.data1;
            end
            WB_SEL_IO: begin
                mux_addr = bus.addr2;
                mux_data = bus.data2;
            end
            default: begin
                mux_addr = bus.addr0;
                mux_data = bus.data0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_we_q   <= 1'b0;
            wb_sel_q  <= WB_SEL_ALU;
            wb_addr_q <= '0;
            wb_data_q <= '0;
            last      <= 2'd2;
        end else if (stage_free) begin
            if (grant != 3'b000) begin
                wb_we_q   <= 1'b1;
                wb_sel_q  <= idx;
                wb_addr_q <= mux_addr;
                wb_data_q <= mux_data;
                last      <= idx;
            end else begin
                // sel/addr/data keep stale values; they are ignored while wb_we is low.
                wb_we_q   <= 1'b0;
            end
        end
    end

    assign bus.grant   = grant;
    assign bus.wb_we   = wb_we_q;
    assign bus.wb_sel  = wb_sel_q;
    assign bus.wb_addr = wb_addr_q;
    assign bus.wb_data = wb_data_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed scenarios plus a randomized run against a queue-free round-robin reference model.
module tb_wb_arbiter;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    wb_arbiter_if #(.DATAWIDTH(16), .ADDRWIDTH(4)) bus ();

    wb_arbiter #(.DATAWIDTH(16), .ADDRWIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [3:0]  src_addr [3];
    logic [15:0] src_data [3];

    task automatic drive_sources();
        bus.addr0 = src_addr[0]; bus.data0 = src_data[0];
        bus.addr1 = src_addr[1]; bus.data1 = src_data[1];
        bus.addr2 = src_addr[2]; bus.data2 = src_data[2];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.req    = 3'b000;
        bus.wb_rdy = 1'b1;
        rst_n      = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        bus.req    = 3'b111;
        bus.wb_rdy = 1'b1;
        rst_n      = 1'b0;
        @(negedge clk);
        checks++; if (bus.grant !== 3'b000) begin failures++; $display("FAIL reset_grant got=%b exp=000", bus.grant); end
        checks++; if (bus.wb_we !== 1'b0) begin failures++; $display("FAIL reset_we got=%b exp=0", bus.wb_we); end
        checks++; if (bus.wb_sel !== 2'b00 || bus.wb_addr !== 4'h0 || bus.wb_data !== 16'h0) begin
            failures++; $display("FAIL reset_regs got sel=%b addr=%h data=%h exp 00/0/0000", bus.wb_sel, bus.wb_addr, bus.wb_data);
        end
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (bus.grant !== 3'b001) begin failures++; $display("FAIL reset_first_grant got=%b exp=001", bus.grant); end
        tick();
        bus.req = 3'b000;
        @(negedge clk);
        checks++; if (bus.wb_we !== 1'b1 || bus.wb_sel !== 2'b00) begin
            failures++; $display("FAIL reset_first_sel got we=%b sel=%b exp we=1 sel=00", bus.wb_we, bus.wb_sel);
        end
        tick();
    endtask

    task automatic test_single();
        do_reset();
        src_addr[1] = 4'h5; src_data[1] = 16'hBEEF;
        drive_sources();
        bus.req = 3'b010;
        @(negedge clk);
        checks++; if (bus.grant !== 3'b010) begin failures++; $display("FAIL single_grant got=%b exp=010", bus.grant); end
        tick();
        bus.req = 3'b000;
        @(negedge clk);
        checks++; if (bus.wb_we !== 1'b1 || bus.wb_sel !== 2'b01 || bus.wb_addr !== 4'h5 || bus.wb_data !== 16'hBEEF) begin
            failures++; $display("FAIL single_out got we=%b sel=%b addr=%h data=%h exp 1/01/5/beef",
                                 bus.wb_we, bus.wb_sel, bus.wb_addr, bus.wb_data);
        end
        tick();
        @(negedge clk);
        checks++; if (bus.wb_we !== 1'b0) begin failures++; $display("FAIL single_idle got we=%b exp=0", bus.wb_we); end
        tick();
    endtask

    task automatic test_rotation();
        logic [2:0] exp_g [6];
        logic [1:0] exp_s [6];
        exp_g = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        exp_s = '{2'b00, 2'b01, 2'b10, 2'b00, 2'b01, 2'b10};
        do_reset();
        bus.req = 3'b111;
        for (int i = 0; i < 7; i++) begin
            if (i == 6) bus.req = 3'b000;
            @(negedge clk);
            if (i < 6) begin
                checks++; if (bus.grant !== exp_g[i]) begin failures++; $display("FAIL rotation_grant[%0d] got=%b exp=%b", i, bus.grant, exp_g[i]); end
            end
            if (i > 0) begin
                checks++; if (bus.wb_we !== 1'b1 || bus.wb_sel !== exp_s[i-1]) begin
                    failures++; $display("FAIL rotation_sel[%0d] got we=%b sel=%b exp we=1 sel=%b", i-1, bus.wb_we, bus.wb_sel, exp_s[i-1]);
                end
            end
            tick();
        end
    endtask

    task automatic test_stall();
        do_reset();
        src_addr[2] = 4'h3; src_data[2] = 16'h1234;
        src_addr[0] = 4'h7; src_data[0] = 16'hABCD;
        drive_sources();
        bus.req = 3'b100;
        @(negedge clk);
        checks++; if (bus.grant !== 3'b100) begin failures++; $display("FAIL stall_src2_grant got=%b exp=100", bus.grant); end
        tick();
        bus.req    = 3'b001;
        bus.wb_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (bus.grant !== 3'b000 || bus.wb_we !== 1'b1 || bus.wb_data !== 16'h1234) begin
                failures++; $display("FAIL stall_hold[%0d] got grant=%b we=%b data=%h exp 000/1/1234", i, bus.grant, bus.wb_we, bus.wb_data);
            end
            tick();
        end
        bus.wb_rdy = 1'b1;
        @(negedge clk);
        checks++; if (bus.grant !== 3'b001 || bus.wb_data !== 16'h1234) begin
            failures++; $display("FAIL stall_release got grant=%b data=%h exp 001/1234", bus.grant, bus.wb_data);
        end
        tick();
        bus.req = 3'b000;
        @(negedge clk);
        checks++; if (bus.wb_we !== 1'b1 || bus.wb_sel !== 2'b00 || bus.wb_data !== 16'hABCD) begin
            failures++; $display("FAIL stall_next got we=%b sel=%b data=%h exp 1/00/abcd", bus.wb_we, bus.wb_sel, bus.wb_data);
        end
        tick();
    endtask

    task automatic test_drop();
        do_reset();
        src_data[2] = 16'h0F0F; src_addr[2] = 4'hC;
        drive_sources();
        bus.req = 3'b001;
        tick();
        // last is now 0 and the stage is busy; hold it so src1 can drop before winning
        bus.req    = 3'b110;
        bus.wb_rdy = 1'b0;
        @(negedge clk);
        checks++; if (bus.grant !== 3'b000) begin failures++; $display("FAIL drop_blocked got=%b exp=000", bus.grant); end
        tick();
        bus.req    = 3'b100;
        bus.wb_rdy = 1'b1;
        @(negedge clk);
        checks++; if (bus.grant !== 3'b100) begin failures++; $display("FAIL drop_src2 got=%b exp=100", bus.grant); end
        tick();
        bus.req = 3'b111;
        @(negedge clk);
        checks++; if (bus.grant !== 3'b001 || bus.wb_sel !== 2'b10 || bus.wb_data !== 16'h0F0F) begin
            failures++; $display("FAIL drop_last got grant=%b sel=%b data=%h exp 001/10/0f0f", bus.grant, bus.wb_sel, bus.wb_data);
        end
        tick();
        bus.req = 3'b000;
        tick();
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        bus.req = 3'b010;
        tick();
        bus.req    = 3'b000;
        bus.wb_rdy = 1'b0;
        @(negedge clk);
        checks++; if (bus.wb_we !== 1'b1) begin failures++; $display("FAIL midrst_pre got we=%b exp=1", bus.wb_we); end
        #2;
        bus.req = 3'b111;
        rst_n   = 1'b0;
        #1;
        checks++; if (bus.wb_we !== 1'b0 || bus.grant !== 3'b000) begin
            failures++; $display("FAIL midrst_async got we=%b grant=%b exp 0/000", bus.wb_we, bus.grant);
        end
        tick();
        rst_n      = 1'b1;
        bus.wb_rdy = 1'b1;
        @(negedge clk);
        checks++; if (bus.grant !== 3'b001) begin failures++; $display("FAIL midrst_last got grant=%b exp=001", bus.grant); end
        tick();
        bus.req = 3'b000;
        tick();
    endtask

    // Reference: output stage as plain variables, arbitration as "first requester after last, mod 3".
    task automatic test_random();
        int          m_last;
        bit          m_we;
        int          m_sel;
        logic [3:0]  m_addr;
        logic [15:0] m_data;
        logic [2:0]  req_v;
        logic [2:0]  exp_g;
        int          win;
        bit          free;
        do_reset();
        m_last = 2; m_we = 0; m_sel = 0; m_addr = '0; m_data = '0;
        req_v  = 3'b000;
        for (int cyc = 0; cyc < 500; cyc++) begin
            for (int s = 0; s < 3; s++) begin
                if (req_v[s]) begin
                    if ($urandom_range(0, 15) == 0) req_v[s] = 1'b0;
                end else if ($urandom_range(0, 2) != 0) begin
                    req_v[s]    = 1'b1;
                    src_addr[s] = 4'($urandom);
                    src_data[s] = 16'($urandom);
                end
            end
            drive_sources();
            bus.req    = req_v;
            bus.wb_rdy = ($urandom_range(0, 9) < 7);
            @(negedge clk);
            free  = !m_we || bus.wb_rdy;
            win   = -1;
            exp_g = 3'b000;
            if (free) begin
                for (int k = 1; k <= 3; k++) begin
                    if (win < 0 && req_v[(m_last + k) % 3]) win = (m_last + k) % 3;
                end
            end
            if (win >= 0) exp_g = 3'b001 << win;
            checks++; if (bus.grant !== exp_g) begin
                failures++; $display("FAIL rand_grant cyc=%0d got=%b exp=%b", cyc, bus.grant, exp_g);
            end
            checks++; if (bus.wb_we !== m_we) begin
                failures++; $display("FAIL rand_we cyc=%0d got=%b exp=%b", cyc, bus.wb_we, m_we);
            end
            if (m_we) begin
                checks++; if (bus.wb_sel !== 2'(m_sel) || bus.wb_addr !== m_addr || bus.wb_data !== m_data) begin
                    failures++; $display("FAIL rand_out cyc=%0d got sel=%b addr=%h data=%h exp sel=%0d addr=%h data=%h",
                                         cyc, bus.wb_sel, bus.wb_addr, bus.wb_data, m_sel, m_addr, m_data);
                end
            end
            @(posedge clk);
            if (free) begin
                if (win >= 0) begin
                    m_we   = 1;
                    m_sel  = win;
                    m_addr = src_addr[win];
                    m_data = src_data[win];
                    m_last = win;
                    req_v[win] = 1'b0;
                end else begin
                    m_we = 0;
                end
            end
            #1;
        end
        bus.req = 3'b000;
        tick();
    endtask

    initial begin
        for (int s = 0; s < 3; s++) begin
            src_addr[s] = '0;
            src_data[s] = '0;
        end
        drive_sources();
        bus.req    = 3'b000;
        bus.wb_rdy = 1'b1;
        #2;
        test_reset();
        test_single();
        test_rotation();
        test_stall();
        test_drop();
        test_reset_mid_stall();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
